// File: rtl/reg_file_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_pkg
//  Description : Shared register-file constants: data width, address width,
//                stack-pointer index and reset value, and the hard-wired zero
//                register index. Also used by the destination-register decoder
//                and the write-back data muxes.
//  Revision    : 1.0  initial release
// ============================================================================
package reg_file_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned SP_IDX   = 29;
    localparam int unsigned SP_INIT  = 128;
    localparam int unsigned ZERO_IDX = 0;

    // Reset value of register idx: SP_INIT for the stack pointer, else zero.
    function automatic logic [DATA_W-1:0] reset_value(input int unsigned idx);
        return (idx == SP_IDX) ? DATA_W'(SP_INIT) : '0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file
//  Description : 2**ADDR_W x DATA_W register file, two combinational read
//                ports and one synchronous write port. Register ZERO_IDX is
//                hard-wired to zero. Reset, which is asynchronous and
//                active-low, clears every register except SP_IDX, which is
//                loaded with SP_INIT.
//  Ports       : clk_i       - clock, state updates on its rising edge
//                rst_i       - asynchronous active-low reset
//                RSaddr_i    - read-port-A address
//                RTaddr_i    - read-port-B address
//                RDaddr_i    - write address
//                RDdata_i    - write data
//                RegWrite_i  - write enable, active-high
//                RSdata_o    - read-port-A data
//                RTdata_o    - read-port-B data
//  Revision    : 1.0  initial release
// ============================================================================
module reg_file
    import reg_file_pkg::*;
#(
    parameter int unsigned DATA_W  = reg_file_pkg::DATA_W,
    parameter int unsigned ADDR_W  = reg_file_pkg::ADDR_W,
    parameter int unsigned SP_IDX  = reg_file_pkg::SP_IDX,
    parameter int unsigned SP_INIT = reg_file_pkg::SP_INIT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] RSaddr_i,
    input  logic [ADDR_W-1:0] RTaddr_i,
    input  logic [ADDR_W-1:0] RDaddr_i,
    input  logic [DATA_W-1:0] RDdata_i,
    input  logic              RegWrite_i,
    output logic [DATA_W-1:0] RSdata_o,
    output logic [DATA_W-1:0] RTdata_o
);

    localparam int unsigned NREG = 2 ** ADDR_W;

    // Combinational view of every register (the zero register included).
    logic [DATA_W-1:0] reg_view [NREG];

    // One-hot per-register write strobe.
    logic [NREG-1:0]   we_d;

    // An X/Z enable evaluates false in the if below, so it never writes.
    always_comb begin
        we_d = '0;
        if (RegWrite_i) begin
            for (int k = 0; k < NREG; k++) begin
                we_d[k] = (RDaddr_i == ADDR_W'(k)) && (k != ZERO_IDX);
            end
        end
    end

    for (genvar k = 0; k < NREG; k++) begin : g_reg
        if (k == ZERO_IDX) begin : g_zero
            // No storage: reads are constant zero, writes fall away.
            assign reg_view[k] = '0;
        end else begin : g_store
            logic [DATA_W-1:0] data_q;

            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i) begin
                    data_q <= (k == SP_IDX) ? DATA_W'(SP_INIT) : '0;
                end else if (we_d[k]) begin
                    data_q <= RDdata_i;
                end
            end

            assign reg_view[k] = data_q;
        end
    end

    // No write bypass: a same-cycle write is visible only after the edge.
    assign RSdata_o = reg_view[RSaddr_i];
    assign RTdata_o = reg_view[RTaddr_i];

endmodule
`default_nettype wire

// File: tb/tb_reg_file.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_file
//  Description : Self-checking bench for reg_file with directed scenarios and
//                a randomized sequence checked against an array-based model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_reg_file;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned SPI   = 29;
    localparam int unsigned SPV   = 128;
    localparam int unsigned NREG  = 2 ** AW;

    logic          clk_i;
    logic          rst_i;
    logic [AW-1:0] RSaddr_i;
    logic [AW-1:0] RTaddr_i;
    logic [AW-1:0] RDaddr_i;
    logic [DW-1:0] RDdata_i;
    logic          RegWrite_i;
    logic [DW-1:0] RSdata_o;
    logic [DW-1:0] RTdata_o;

    int total = 0;
    int bad   = 0;

    // Architectural model: what each register should hold.
    logic [DW-1:0] mdl [NREG];

    reg_file #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .SP_IDX (SPI),
        .SP_INIT(SPV)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .RSaddr_i  (RSaddr_i),
        .RTaddr_i  (RTaddr_i),
        .RDaddr_i  (RDaddr_i),
        .RDdata_i  (RDdata_i),
        .RegWrite_i(RegWrite_i),
        .RSdata_o  (RSdata_o),
        .RTdata_o  (RTdata_o)
    );

    // Clock held low for a while so reset can be checked with no edge.
    initial begin
        clk_i = 1'b0;
        #40;
        forever #5 clk_i = ~clk_i;
    end

    function automatic logic [DW-1:0] mdl_read(input logic [AW-1:0] a);
        return (a == '0) ? '0 : mdl[a];
    endfunction

    task automatic mdl_reset();
        for (int k = 0; k < NREG; k++) mdl[k] = '0;
        mdl[SPI] = DW'(SPV);
    endtask

    // Advance one rising edge, apply the architectural write rule, and
    // return 1 time unit after the edge.
    task automatic step();
        total++;
        if ($isunknown(RegWrite_i)) begin
            bad++;
            $display("FAIL we_known: RegWrite_i=%b required 0 or 1", RegWrite_i);
        end
        @(posedge clk_i);
        if (rst_i === 1'b1 && RegWrite_i === 1'b1 && RDaddr_i != '0)
            mdl[RDaddr_i] = RDdata_i;
        #1;
    endtask

    task automatic test_reset();
        logic [AW-1:0] addrs [4];
        logic [DW-1:0] exps  [4];
        addrs = '{5'd0, 5'd1, 5'd29, 5'd31};
        exps  = '{32'd0, 32'd0, 32'd128, 32'd0};
        rst_i = 1'b1; RegWrite_i = 1'b0;
        RDaddr_i = '0; RDdata_i = '0; RSaddr_i = '0; RTaddr_i = '0;
        #2;
        rst_i = 1'b0;
        #2;
        for (int i = 0; i < 4; i++) begin
            RSaddr_i = addrs[i];
            RTaddr_i = addrs[i];
            #2;
            total++;
            if (RSdata_o !== exps[i] || RTdata_o !== exps[i]) begin
                bad++;
                $display("FAIL reset_read[%0d]: RS=%h RT=%h required %h",
                         addrs[i], RSdata_o, RTdata_o, exps[i]);
            end
        end
        mdl_reset();
        // Writes blocked while in reset.
        RDaddr_i = 5'd3; RDdata_i = 32'hCAFE_0003; RegWrite_i = 1'b1;
        step();
        RSaddr_i = 5'd3;
        #1;
        total++;
        if (RSdata_o !== 32'd0) begin
            bad++;
            $display("FAIL reset_blocks_write: got %h required 00000000", RSdata_o);
        end
        RegWrite_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
    endtask

    task automatic test_basic_write();
        RDaddr_i = 5'd5; RDdata_i = 32'hDEADBEEF; RegWrite_i = 1'b1;
        step();
        RegWrite_i = 1'b0; RSaddr_i = 5'd5;
        #1;
        total++;
        if (RSdata_o !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL basic_write: got %h required deadbeef", RSdata_o);
        end
        RDaddr_i = 5'd6; RDdata_i = 32'h12345678; RegWrite_i = 1'b0;
        step();
        RSaddr_i = 5'd6;
        #1;
        total++;
        if (RSdata_o !== 32'd0) begin
            bad++;
            $display("FAIL write_disabled: got %h required 00000000", RSdata_o);
        end
    endtask

    task automatic test_zero_reg();
        RDaddr_i = 5'd0; RDdata_i = 32'hFFFFFFFF; RegWrite_i = 1'b1;
        step();
        RegWrite_i = 1'b0; RSaddr_i = 5'd0; RTaddr_i = 5'd0;
        #1;
        total++;
        if (RSdata_o !== 32'd0 || RTdata_o !== 32'd0) begin
            bad++;
            $display("FAIL zero_reg: RS=%h RT=%h required 00000000", RSdata_o, RTdata_o);
        end
    endtask

    task automatic test_read_during_write();
        RDaddr_i = 5'd7; RDdata_i = 32'h11; RegWrite_i = 1'b1;
        step();
        RSaddr_i = 5'd7; RTaddr_i = 5'd7; RDdata_i = 32'h22;
        #1;
        total++;
        if (RSdata_o !== 32'h11 || RTdata_o !== 32'h11) begin
            bad++;
            $display("FAIL rdw_before: RS=%h RT=%h required 00000011", RSdata_o, RTdata_o);
        end
        step();
        RegWrite_i = 1'b0;
        total++;
        if (RSdata_o !== 32'h22 || RTdata_o !== 32'h22) begin
            bad++;
            $display("FAIL rdw_after: RS=%h RT=%h required 00000022", RSdata_o, RTdata_o);
        end
    endtask

    task automatic test_reset_mid_write();
        RDaddr_i = 5'd29; RDdata_i = 32'h500; RegWrite_i = 1'b1;
        RSaddr_i = 5'd29; RTaddr_i = 5'd5;
        #2;
        rst_i = 1'b0;
        mdl_reset();
        #1;
        total++;
        if (RSdata_o !== 32'd128 || RTdata_o !== 32'd0) begin
            bad++;
            $display("FAIL rst_mid_immediate: RS=%h RT=%h required 00000080 00000000",
                     RSdata_o, RTdata_o);
        end
        step();
        total++;
        if (RSdata_o !== 32'd128) begin
            bad++;
            $display("FAIL rst_mid_after_edge: got %h required 00000080", RSdata_o);
        end
        // First edge after release with the enable high must write.
        @(negedge clk_i);
        rst_i = 1'b1;
        step();
        RegWrite_i = 1'b0;
        total++;
        if (RSdata_o !== 32'h500) begin
            bad++;
            $display("FAIL first_write_after_reset: got %h required 00000500", RSdata_o);
        end
    endtask

    task automatic test_sweep();
        for (int k = 1; k < NREG; k++) begin
            RDaddr_i = AW'(k); RDdata_i = DW'(k * 3); RegWrite_i = 1'b1;
            step();
        end
        RegWrite_i = 1'b0;
        for (int k = 0; k < NREG; k++) begin
            RSaddr_i = AW'(k); RTaddr_i = AW'(k);
            #1;
            total++;
            if (RSdata_o !== DW'(k * 3) || RTdata_o !== DW'(k * 3)) begin
                bad++;
                $display("FAIL sweep[%0d]: RS=%h RT=%h required %h",
                         k, RSdata_o, RTdata_o, DW'(k * 3));
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            RegWrite_i = ($urandom_range(0, 3) != 0);
            RDaddr_i   = AW'($urandom_range(0, NREG - 1));
            RDdata_i   = DW'($urandom);
            RSaddr_i   = AW'($urandom_range(0, NREG - 1));
            RTaddr_i   = ($urandom_range(0, 3) == 0) ? RSaddr_i : RDaddr_i;
            #1;
            total++;
            if (RSdata_o !== mdl_read(RSaddr_i) || RTdata_o !== mdl_read(RTaddr_i)) begin
                bad++;
                $display("FAIL random[%0d]: RS[%0d]=%h RT[%0d]=%h required %h %h",
                         i, RSaddr_i, RSdata_o, RTaddr_i, RTdata_o,
                         mdl_read(RSaddr_i), mdl_read(RTaddr_i));
            end
            step();
        end
        RegWrite_i = 1'b0;
        for (int k = 0; k < NREG; k++) begin
            RSaddr_i = AW'(k); RTaddr_i = AW'(NREG - 1 - k);
            #1;
            total++;
            if (RSdata_o !== mdl_read(RSaddr_i) || RTdata_o !== mdl_read(RTaddr_i)) begin
                bad++;
                $display("FAIL random_final[%0d]: RS=%h RT=%h required %h %h",
                         k, RSdata_o, RTdata_o, mdl_read(RSaddr_i), mdl_read(RTaddr_i));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_zero_reg();
        test_read_during_write();
        test_reset_mid_write();
        test_sweep();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
